// File: rtl/trace_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_pkg: shared types, stamp width and record-width helper for the     |
// | trace_capture slice (TRACE_TIMESTAMP_EN widens records).  Rev 1.0        |
// +--------------------------------------------------------------------------+
package trace_pkg;

    typedef enum logic [1:0] {
        TR_IDLE    = 2'd0,
        TR_ARMED   = 2'd1,
        TR_CAPTURE = 2'd2,
        TR_DONE    = 2'd3
    } tr_state_t;

    localparam int TR_STAMP_W = 16;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TR_STAMP_EN = 1'b1;
`else
    localparam bit TR_STAMP_EN = 1'b0;
`endif

    function automatic int rec_width(input int op_w, input int val_w, input int addr_w);
        return op_w + val_w + addr_w + (TR_STAMP_EN ? TR_STAMP_W : 0);
    endfunction

    localparam int REC_W = rec_width(8, 8, 8);

endpackage
`default_nettype wire

// File: rtl/trace_capture_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_capture_if: proc sample bus plus FWFT read port.  Rev 1.0          |
// +--------------------------------------------------------------------------+
interface trace_capture_if #(
    parameter int OP_W   = 8,
    parameter int VAL_W  = 8,
    parameter int ADDR_W = 8
);
    localparam int REC_W = trace_pkg::rec_width(OP_W, VAL_W, ADDR_W);

    logic              smp_valid;
    logic [OP_W-1:0]   op_code;
    logic [VAL_W-1:0]  alu_out;
    logic [ADDR_W-1:0] dest_addr;
    logic              rd_valid;
    logic              rd_ready;
    logic [REC_W-1:0]  rd_data;

    modport master (
        output smp_valid, op_code, alu_out, dest_addr, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  smp_valid, op_code, alu_out, dest_addr, rd_ready,
        output rd_valid, rd_data
    );

endinterface
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_fifo: DEPTH x W register FIFO with optional overwrite-oldest.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 24,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             overwrite,
    input  wire logic [W-1:0]     wr_data,
    output logic      [W-1:0]     rd_data,
    output logic      [CNT_W-1:0] level,
    output logic                  full,
    output logic                  empty
);
    localparam int               PTR_W        = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_full_level = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_level;

    logic w_pop_ok;
    logic w_push_ok;
    logic w_ovw;

    assign full      = (r_level == c_full_level);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

    // A same-cycle pop frees the slot, so overwrite only happens without one.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok || overwrite);
    assign w_ovw     = push && full && !w_pop_ok && overwrite;

    always_ff @(posedge clk) begin
        if (w_push_ok && !clr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok || w_ovw) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok && !w_ovw) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_capture: triggered execution-trace buffer for proc observation     |
// | outputs; TRACE_TIMESTAMP_EN prepends a 16-bit cycle stamp.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int OP_W   = 8,
    parameter int VAL_W  = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             arm,
    input  wire logic             clear,
    input  wire logic             ring_mode,
    input  wire logic             trig_any,
    input  wire logic [OP_W-1:0]  trig_op,
    input  wire logic [CNT_W-1:0] cap_len,
    trace_capture_if.slave        bus,
    output logic      [CNT_W-1:0] level,
    output logic      [1:0]       state_o,
    output logic                  overflow,
    output logic                  done
);
    localparam int REC_W = rec_width(OP_W, VAL_W, ADDR_W);

    localparam logic [1:0] c_st_idle    = TR_IDLE;
    localparam logic [1:0] c_st_armed   = TR_ARMED;
    localparam logic [1:0] c_st_capture = TR_CAPTURE;
    localparam logic [1:0] c_st_done    = TR_DONE;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cap_cnt;
    logic             r_overflow;

    logic             w_pop;
    logic             w_trig;
    logic             w_smp;
    logic             w_blocked;
    logic             w_drop;
    logic             w_ovw;
    logic             w_push;
    logic             w_len_hit;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [REC_W-1:0] w_rec;

`ifdef TRACE_TIMESTAMP_EN
    logic [TR_STAMP_W-1:0] r_stamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stamp <= '0;
        end else if (clear) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + 1'b1;
        end
    end

    assign w_rec = {r_stamp, bus.op_code, bus.alu_out, bus.dest_addr};
`else
    assign w_rec = {bus.op_code, bus.alu_out, bus.dest_addr};
`endif

    assign w_pop     = !w_empty && bus.rd_ready;
    assign w_trig    = (r_state == c_st_armed) && bus.smp_valid &&
                       (trig_any || (bus.op_code == trig_op));
    // The triggering sample is itself the first captured record.
    assign w_smp     = !clear && (w_trig || ((r_state == c_st_capture) && bus.smp_valid));
    assign w_blocked = w_full && !w_pop;
    assign w_drop    = w_smp && w_blocked && !ring_mode;
    assign w_ovw     = w_smp && w_blocked && ring_mode;
    assign w_push    = w_smp && !w_drop;
    assign w_cnt_nxt = r_cap_cnt + 1'b1;
    assign w_len_hit = w_push && (cap_len != '0) && (w_cnt_nxt == cap_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_st_idle;
            r_cap_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_state    <= c_st_idle;
            r_cap_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_smp) begin
                r_state <= (w_len_hit || w_drop) ? c_st_done : c_st_capture;
            end else if ((r_state == c_st_idle) && arm) begin
                r_state   <= c_st_armed;
                r_cap_cnt <= '0;
            end
            if (w_push) begin
                r_cap_cnt <= w_cnt_nxt;
            end
            if (w_drop || w_ovw) begin
                r_overflow <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear),
        .push      (w_push),
        .pop       (w_pop),
        .overwrite (ring_mode),
        .wr_data   (w_rec),
        .rd_data   (bus.rd_data),
        .level     (level),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign bus.rd_valid = !w_empty;
    assign state_o      = r_state;
    assign overflow     = r_overflow;
    assign done         = (r_state == c_st_done);

endmodule
`default_nettype wire
